mcycle_seq: RTL and testbench

MCYCLE_SEQ -- requirements
Module: mcycle_seq

---
 rtl/mcycle_pkg.sv | 41 ++++
 rtl/mcycle_decode.sv | 48 ++++
 rtl/mcycle_seq.sv | 169 ++++++++++++++++
 tb/tb_mcycle_seq.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcycle_pkg.sv
// rtl/mcycle_pkg.sv - shared states, opcodes and ALU codes for the multicycle sequencer
// Purpose: common definitions imported by mcycle_decode and mcycle_seq.
// Ports: none (package).
package mcycle_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_BRF,
    S_HALT
  } state_t;

  // What the sequencer has to do with an instruction once decoded
  typedef enum logic [2:0] {
    CL_HALT,
    CL_ILLEGAL,
    CL_JUMP,
    CL_REG,
    CL_MEM,
    CL_BRANCH
  } op_class_t;

  localparam logic [3:0] OP_HALT = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_SUBI = 4'h2;
  localparam logic [3:0] OP_LW   = 4'h3;
  localparam logic [3:0] OP_SW   = 4'h4;
  localparam logic [3:0] OP_J    = 4'h5;
  localparam logic [3:0] OP_BEQ  = 4'h6;
  // op[3] set marks the register-register ALU group
  localparam logic       OP_ALU  = 1'b1;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_CMP = 3'b101;

endpackage

// File: rtl/mcycle_decode.sv
// rtl/mcycle_decode.sv - combinational opcode decoder for the multicycle sequencer
// Purpose: map the 4-bit opcode to ALU control, ALU B-source select and a sequencing class.
// Ports:
//   op        in  4  opcode field of the instruction register
//   alu_ctrl  out 3  ALU operation
//   alu_b_sel out 1  1 = rt field as immediate, 0 = register port 2
//   op_class  out 3  sequencing class consumed by the FSM
module mcycle_decode
  import mcycle_pkg::*;
(
  input  logic [3:0] op,
  output logic [2:0] alu_ctrl,
  output logic       alu_b_sel,
  output op_class_t  op_class
);

  always_comb begin
    alu_ctrl  = ALU_ADD;
    alu_b_sel = 1'b0;
    op_class  = CL_REG;
    if (op[3] == OP_ALU) begin
      alu_ctrl = op[2:0];
      // 1110 and 1111 are unassigned inside the ALU group
      if (op[2:1] == 2'b11) op_class = CL_ILLEGAL;
    end else begin
      case (op)
        OP_HALT: op_class = CL_HALT;
        OP_ADDI: alu_b_sel = 1'b1;
        OP_SUBI: begin
          alu_ctrl  = ALU_SUB;
          alu_b_sel = 1'b1;
        end
        OP_LW, OP_SW: begin
          // address add: base register plus immediate offset
          alu_b_sel = 1'b1;
          op_class  = CL_MEM;
        end
        OP_J:    op_class = CL_JUMP;
        OP_BEQ: begin
          alu_ctrl = ALU_CMP;
          op_class = CL_BRANCH;
        end
        default: op_class = CL_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/mcycle_seq.sv
// rtl/mcycle_seq.sv - multicycle instruction sequencer (FSM, PC and instruction register)
// Purpose: fetch, decode and step each instruction through EXEC/MEM/WB/BRF.
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   start                    run pulse, honoured in IDLE and HALT only
//   imem_req/addr/ack/rdata  instruction fetch handshake
//   dmem_req/we/ack          data-memory handshake
//   op, rs, rt, rd           instruction register fields
//   alu_ctrl, alu_b_sel      ALU operation and B source
//   alu_result               ALU output, used for the branch decision
//   reg_we, wb_sel           register write strobe and source (1 = memory)
//   pc, busy, halted, illegal status
module mcycle_seq
  import mcycle_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic [3:0]      op,
  output logic [3:0]      rs,
  output logic [3:0]      rt,
  output logic [3:0]      rd,
  output logic [2:0]      alu_ctrl,
  output logic            alu_b_sel,
  input  logic [3:0]      alu_result,
  output logic            reg_we,
  output logic            wb_sel,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic            illegal
);

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic [15:0]     ir, ir_nxt;
  logic            illegal_nxt;
  op_class_t       op_class;

  assign op = ir[15:12];
  assign rs = ir[11:8];
  assign rt = ir[7:4];
  assign rd = ir[3:0];

  mcycle_decode u_decode (
    .op        (op),
    .alu_ctrl  (alu_ctrl),
    .alu_b_sel (alu_b_sel),
    .op_class  (op_class)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      pc      <= '0;
      ir      <= '0;
      illegal <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      ir      <= ir_nxt;
      illegal <= illegal_nxt;
    end
  end

  // Strobes depend only on state and the latched IR, never on the acks.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    ir_nxt      = ir;
    illegal_nxt = illegal;
    imem_req    = 1'b0;
    imem_addr   = pc;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    reg_we      = 1'b0;
    wb_sel      = 1'b0;
    busy        = 1'b1;
    halted      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_nxt    = imem_rdata;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        case (op_class)
          CL_HALT:    state_nxt = S_HALT;
          CL_ILLEGAL: begin
            state_nxt   = S_HALT;
            illegal_nxt = 1'b1;
          end
          CL_JUMP: begin
            pc_nxt    = PC_W'({rt, rd});
            state_nxt = S_FETCH;
          end
          default:    state_nxt = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (op_class)
          CL_MEM:    state_nxt = S_MEM;
          CL_BRANCH: begin
            if (alu_result == 4'd1) begin
              state_nxt = S_BRF;
            end else begin
              pc_nxt    = pc + PC_W'(2);
              state_nxt = S_FETCH;
            end
          end
          default:   state_nxt = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op == OP_SW);
        if (dmem_ack) begin
          if (op == OP_SW) begin
            pc_nxt    = pc + PC_W'(1);
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we    = 1'b1;
        wb_sel    = (op == OP_LW);
        pc_nxt    = pc + PC_W'(1);
        state_nxt = S_FETCH;
      end
      S_BRF: begin
        // offset word sits right after the branch instruction
        imem_req  = 1'b1;
        imem_addr = pc + PC_W'(1);
        if (imem_ack) begin
          pc_nxt    = pc + PC_W'(2) + PC_W'(imem_rdata[7:0]);
          state_nxt = S_FETCH;
        end
      end
      S_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
        if (start) begin
          pc_nxt      = pc + PC_W'(1);
          illegal_nxt = 1'b0;
          state_nxt   = S_FETCH;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mcycle_seq.sv
// tb/tb_mcycle_seq.sv - self-checking bench for mcycle_seq
module tb_mcycle_seq;

  typedef struct {
    logic [15:0] ir;
    logic [3:0]  ares;
    logic [15:0] bw;
    int          id;
    int          dd;
    logic [7:0]  exp_pc;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [7:0] npc;
    int         lat;
    bit         halt;
    bit         ill;
    bit         rw;
    bit         from_mem;
    bit         mem;
    bit         mem_we;
    int         acks;
    logic [2:0] actrl;
    bit         bsel;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, start, imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
  logic        alu_b_sel, reg_we, wb_sel, busy, halted, illegal;
  logic [7:0]  imem_addr, pc;
  logic [15:0] imem_rdata;
  logic [3:0]  op, rs, rt, rd, alu_result;
  logic [2:0]  alu_ctrl;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  mcycle_seq #(.PC_W(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .op(op), .rs(rs), .rt(rt), .rd(rd),
    .alu_ctrl(alu_ctrl), .alu_b_sel(alu_b_sel), .alu_result(alu_result),
    .reg_we(reg_we), .wb_sel(wb_sel),
    .pc(pc), .busy(busy), .halted(halted), .illegal(illegal)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic finish_up();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // Instruction-level reference: what one instruction does to pc, how long it
  // takes with the given handshake delays, and which strobes it must produce.
  function automatic exp_t model(input logic [15:0] ir, input logic [7:0] pc0, input logic [3:0] ares,
                                 input logic [15:0] bw, input int id, input int dd);
    exp_t e;
    logic [3:0] o;
    o = ir[15:12];
    e = '{default: 0};
    e.npc   = pc0;
    e.acks  = 1;
    e.lat   = 2 + id;
    e.actrl = o[3] ? o[2:0] : (o == 4'd6) ? 3'b101 : (o == 4'd2) ? 3'b001 : 3'b000;
    e.bsel  = (o >= 4'd1 && o <= 4'd4);
    if (o == 4'd0) begin
      e.halt = 1;
    end else if (o == 4'd7 || o >= 4'd14) begin
      e.halt = 1;
      e.ill  = 1;
    end else if (o == 4'd5) begin
      e.npc = ir[7:0];
    end else if (o == 4'd3 || o == 4'd4) begin
      e.mem      = 1;
      e.mem_we   = (o == 4'd4);
      e.rw       = (o == 4'd3);
      e.from_mem = (o == 4'd3);
      e.lat      = ((o == 4'd3) ? 5 : 4) + id + dd;
      e.npc      = pc0 + 8'd1;
    end else if (o == 4'd6) begin
      if (ares == 4'd1) begin
        e.acks = 2;
        e.lat  = 4 + 2 * id;
        e.npc  = pc0 + 8'd2 + bw[7:0];
      end else begin
        e.lat = 3 + id;
        e.npc = pc0 + 8'd2;
      end
    end else begin
      e.rw  = 1;
      e.lat = 4 + id;
      e.npc = pc0 + 8'd1;
    end
    return e;
  endfunction

  // Entered at a negedge with the DUT in FETCH; returns at the negedge where the
  // next FETCH (or HALT) is visible.
  task automatic run_instr(input logic [15:0] ir, input logic [3:0] ares, input logic [15:0] bw,
                           input int id, input int dd, input bit noise, input logic [7:0] pc0,
                           input exp_t e);
    int t, acks, irc, drc, dreq_n, we_n, we_t;
    bit wbs, dwe, done;
    t = 1; acks = 0; irc = 0; drc = 0; dreq_n = 0; we_n = 0; we_t = 0;
    wbs = 0; dwe = 0; done = 0;
    alu_result = ares;
    while (!done) begin
      if (halted || (acks == e.acks && imem_req)) begin
        done = 1;
      end else begin
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        if (imem_req) begin
          irc++;
          if (irc > id) begin
            chk("imem_addr", imem_addr, (acks == 0) ? pc0 : pc0 + 8'd1);
            imem_ack   = 1'b1;
            imem_rdata = (acks == 0) ? ir : bw;
            acks++;
            irc = 0;
          end
        end else if (noise && $urandom_range(0, 3) == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = 16'($urandom);
        end
        if (dmem_req) begin
          dreq_n++;
          drc++;
          dwe |= dmem_we;
          if (drc > dd) begin
            dmem_ack = 1'b1;
            drc = 0;
          end
        end else if (noise && $urandom_range(0, 3) == 0) begin
          dmem_ack = 1'b1;
        end
        if (reg_we) begin
          we_n++;
          we_t = t;
          wbs  = wb_sel;
        end
        if (t > 60) begin
          checks++;
          errors++;
          $display("FAIL timeout: instr 0x%h ran %0d cycles, want %0d", ir, t, e.lat);
          finish_up();
        end
        @(negedge clk);
        t++;
      end
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    start    = 1'b0;
    chk("latency", t - 1, e.lat);
    chk("pc", pc, e.npc);
    chk("halted", halted, e.halt);
    chk("illegal", illegal, e.ill);
    chk("busy", busy, !e.halt);
    chk("reg_we_count", we_n, e.rw);
    if (e.rw) begin
      chk("reg_we_cycle", we_t, e.lat);
      chk("wb_sel", wbs, e.from_mem);
    end
    chk("dmem_req_cycles", dreq_n, e.mem ? dd + 1 : 0);
    chk("dmem_we", dwe, e.mem_we);
    chk("ir_fields", {op, rs, rt, rd}, ir);
    chk("alu_ctrl", alu_ctrl, e.actrl);
    chk("alu_b_sel", alu_b_sel, e.bsel);
  endtask

  initial begin
    vec_t       vecs[13];
    exp_t       e;
    logic [7:0] mpc;
    logic [15:0] rir, rbw;
    logic [3:0] rares;
    int         rid, rdd, n;

    vecs[0]  = '{16'h1012, 4'd0, 16'h0000, 0, 0, 8'd1,   4};
    vecs[1]  = '{16'h3123, 4'd0, 16'h0000, 0, 3, 8'd2,   8};
    vecs[2]  = '{16'h5004, 4'd0, 16'h0000, 0, 0, 8'd4,   2};
    vecs[3]  = '{16'h6000, 4'd1, 16'h0006, 0, 0, 8'd12,  4};
    vecs[4]  = '{16'h5004, 4'd0, 16'h0000, 0, 0, 8'd4,   2};
    vecs[5]  = '{16'h6000, 4'd0, 16'h0006, 0, 0, 8'd6,   3};
    vecs[6]  = '{16'h50FF, 4'd0, 16'h0000, 0, 0, 8'd255, 2};
    vecs[7]  = '{16'h1000, 4'd0, 16'h0000, 0, 0, 8'd0,   4};
    vecs[8]  = '{16'h5003, 4'd0, 16'h0000, 0, 0, 8'd3,   2};
    vecs[9]  = '{16'h4000, 4'd0, 16'h0000, 0, 2, 8'd4,   6};
    vecs[10] = '{16'h8123, 4'd0, 16'h0000, 2, 0, 8'd5,   6};
    vecs[11] = '{16'h2345, 4'd0, 16'h0000, 1, 0, 8'd6,   5};
    vecs[12] = '{16'hF000, 4'd0, 16'h0000, 0, 0, 8'd6,   2};

    rst = 1'b0; start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    imem_rdata = 16'h0; alu_result = 4'h0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_pc", pc, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_reg_we", reg_we, 0);
    chk("rst_ir", {op, rs, rt, rd}, 16'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_imem_req", imem_req, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_fetch", imem_req, 1);

    mpc = 8'd0;
    for (int i = 0; i < 13; i++) begin
      e = model(vecs[i].ir, mpc, vecs[i].ares, vecs[i].bw, vecs[i].id, vecs[i].dd);
      e.npc = vecs[i].exp_pc;
      e.lat = vecs[i].exp_lat;
      run_instr(vecs[i].ir, vecs[i].ares, vecs[i].bw, vecs[i].id, vecs[i].dd, 1'b0, mpc, e);
      mpc = vecs[i].exp_pc;
    end

    // HALT holds pc; start resumes one past the halting instruction
    @(negedge clk);
    chk("halt_pc_frozen", pc, 8'd6);
    chk("halt_hold", halted, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("resume_illegal", illegal, 0);
    chk("resume_halted", halted, 0);
    chk("resume_req", imem_req, 1);
    chk("resume_addr", imem_addr, 8'd7);

    // Reset while a load waits on dmem_ack
    imem_ack = 1'b1;
    imem_rdata = 16'h3000;
    @(negedge clk);
    imem_ack = 1'b0;
    n = 0;
    while (!dmem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("mem_entered", dmem_req, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_dmem_req", dmem_req, 0);
    chk("midrst_pc", pc, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ir", {op, rs, rt, rd}, 16'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("postrst_idle", busy, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("postrst_addr", imem_addr, 8'd0);
    chk("postrst_req", imem_req, 1);

    // Random instructions with spurious acks and start noise
    mpc = 8'd0;
    for (int i = 0; i < 40; i++) begin
      rir   = 16'($urandom);
      rbw   = 16'($urandom);
      rares = ($urandom_range(0, 1) == 1) ? 4'd1 : 4'($urandom);
      rid   = $urandom_range(0, 2);
      rdd   = $urandom_range(0, 3);
      e = model(rir, mpc, rares, rbw, rid, rdd);
      run_instr(rir, rares, rbw, rid, rdd, 1'b1, mpc, e);
      mpc = e.npc;
      if (e.halt) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mpc = mpc + 8'd1;
        chk("rnd_resume_illegal", illegal, 0);
        chk("rnd_resume_addr", imem_addr, mpc);
      end
    end

    finish_up();
  end

endmodule
